his_reader_peak: RTL

- Read-side counterpart of the histogram builder.
- After a histogram frame is finished, it sweeps the histogram RAM from bin 0 to BIN_NUM-1 over a 1-cycle-latency read port.
- It streams every bin count downstream with a valid/ready handshake, clears each bin behind the read, and reports the peak bin and peak count at the end of the sweep.
- It feeds the downstream distance/peak-processing stage and returns a zeroed RAM to the builder.

---
 rtl/his_reader_peak_pkg.sv | 19 +
 rtl/his_rd_fifo.sv | 52 +++++
 rtl/his_reader_peak.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/his_reader_peak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : his_reader_peak_pkg
// Description : Shared defaults and sweep FSM encodings for the histogram reader.
// Revision    : 1.0 - initial release
// ============================================================================
package his_reader_peak_pkg;

    localparam int c_NB      = 8;
    localparam int c_BIN_NUM = 256;
    localparam int c_CW      = 16;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/his_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : his_rd_fifo
// Description : Two-entry FIFO holding {count, index, last} for the bin stream.
// Revision    : 1.0 - initial release
// ============================================================================
module his_rd_fifo #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop_ok;
    logic         w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/his_reader_peak.sv
`default_nettype none
// ============================================================================
// Module      : his_reader_peak
// Description : Sweeps the histogram RAM, streams and clears every bin, and
//               reports the peak bin/count at the end of the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module his_reader_peak
    import his_reader_peak_pkg::*;
#(
    parameter int NB      = c_NB,
    parameter int BIN_NUM = c_BIN_NUM,
    parameter int CW      = c_CW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    output logic          busy,
    output logic          rd_en,
    output logic [NB-1:0] rd_addr,
    input  logic [CW-1:0] rd_data,
    output logic          clr_en,
    output logic [NB-1:0] clr_addr,
    output logic          bin_valid,
    input  logic          bin_ready,
    output logic [CW-1:0] bin_data,
    output logic [NB-1:0] bin_idx,
    output logic          bin_last,
    output logic          done,
    output logic [NB-1:0] peak_bin,
    output logic [CW-1:0] peak_count
);

    localparam int            c_FW        = CW + NB + 1;
    localparam logic [NB-1:0] c_LAST_ADDR = NB'(BIN_NUM - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [NB-1:0]   r_addr;
    logic            r_inflight;
    logic [NB-1:0]   r_infl_idx;
    logic            r_infl_last;
    logic [1:0]      w_count;
    logic [c_FW-1:0] w_head;
    logic [CW-1:0]   w_head_data;
    logic [NB-1:0]   w_head_idx;
    logic            w_head_last;
    logic            w_valid;
    logic            w_pop;
    logic [1:0]      w_occ;
    logic            w_rd_en;
    logic            w_last_rd;
    logic            w_start_ok;
    logic [CW-1:0]   r_max;
    logic [NB-1:0]   r_max_idx;
    logic [CW-1:0]   w_max_nxt;
    logic [NB-1:0]   w_max_idx_nxt;
    logic [NB-1:0]   r_peak_bin;
    logic [CW-1:0]   r_peak_count;

    his_rd_fifo #(
        .W (c_FW)
    ) u_fifo (
        .clk         (clk),
        .rst         (res),
        .i_push      (r_inflight),
        .i_push_data ({rd_data, r_infl_idx, r_infl_last}),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign {w_head_data, w_head_idx, w_head_last} = w_head;
    assign w_valid    = (w_count != 2'd0);
    assign w_pop      = w_valid && bin_ready;
    assign w_start_ok = (r_state == c_ST_IDLE) && start;

    // Entries that will occupy the FIFO after this cycle's pop; count+inflight never exceeds 2.
    assign w_occ     = (w_count - {1'b0, w_pop}) + {1'b0, r_inflight};
    assign w_rd_en   = (r_state == c_ST_READ) && (w_occ < 2'd2);
    assign w_last_rd = w_rd_en && (r_addr == c_LAST_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_READ;
            c_ST_READ:  if (w_last_rd) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (!r_inflight && ((w_count - {1'b0, w_pop}) == 2'd0)) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_max_nxt     = r_max;
        w_max_idx_nxt = r_max_idx;
        if (w_pop && (w_head_data > r_max)) begin
            w_max_nxt     = w_head_data;
            w_max_idx_nxt = w_head_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state      <= c_ST_IDLE;
            r_addr       <= '0;
            r_inflight   <= 1'b0;
            r_infl_idx   <= '0;
            r_infl_last  <= 1'b0;
            r_max        <= '0;
            r_max_idx    <= '0;
            r_peak_bin   <= '0;
            r_peak_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_inflight  <= w_rd_en;
            r_infl_idx  <= r_addr;
            r_infl_last <= w_last_rd;
            if (w_start_ok) begin
                r_addr    <= '0;
                r_max     <= '0;
                r_max_idx <= '0;
            end else begin
                if (w_rd_en) begin
                    r_addr <= w_last_rd ? '0 : r_addr + 1'b1;
                end
                r_max     <= w_max_nxt;
                r_max_idx <= w_max_idx_nxt;
            end
            // Latch on entry to DONE so the result is valid alongside the done pulse.
            if ((r_state == c_ST_DRAIN) && (w_state_nxt == c_ST_DONE)) begin
                r_peak_bin   <= w_max_idx_nxt;
                r_peak_count <= w_max_nxt;
            end
        end
    end

    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign rd_en      = w_rd_en;
    assign rd_addr    = r_addr;
    assign clr_en     = w_rd_en;
    assign clr_addr   = r_addr;
    assign bin_valid  = w_valid;
    assign bin_data   = w_head_data;
    assign bin_idx    = w_head_idx;
    assign bin_last   = w_head_last;
    assign peak_bin   = r_peak_bin;
    assign peak_count = r_peak_count;

endmodule
`default_nettype wire
